// File: rtl/usb3_tx_scramble.sv
// ---------------------------------------------------------------------------
// usb3_tx_scramble
//   USB 3.0 TX scrambler with scheduled SKP insertion and logical idle.
//   Sits between the link-layer TX word stream and the PHY TX pins.
//   Four symbols per clock; bits [31:24] are the first symbol on the wire.
//
// Ports
//   local_clk        sole clock
//   reset            asynchronous, active-high reset
//   enable           1 = scramble D symbols, 0 = pass through (LFSR held at seed)
//   in_valid         upstream word valid
//   in_ready         word accepted this cycle (low while a SKP word is sent)
//   in_data          upstream symbols
//   in_datak         K flag per byte lane
//   in_hold          upstream is mid-packet / mid-ordered-set; defers SKP
//   tx_data          symbols to PHY
//   tx_datak         K flags to PHY
//   skp_sent         high while a SKP word is on tx_data
//   err_skp_overflow sticky; a SKP request arrived with the pending count full
//   skp_count        (only with USB3_TX_SKP_STATS_EN) saturating SKP word count
//
// Optional build macro: USB3_TX_SKP_STATS_EN adds the skp_count output.
// ---------------------------------------------------------------------------
module usb3_tx_scramble #(
    parameter int unsigned SKP_INTERVAL = 176,
    parameter int unsigned PEND_MAX     = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hFFFF
) (
    input  logic        local_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_hold,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_datak,
    output logic        skp_sent,
`ifdef USB3_TX_SKP_STATS_EN
    output logic [15:0] skp_count,
`endif
    output logic        err_skp_overflow
);

    localparam int unsigned CNT_W  = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
    localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);
    localparam logic [7:0]  COM_SYM  = 8'hBC;
    localparam logic [7:0]  SKP_SYM  = 8'h3C;
    localparam logic [31:0] SKP_WORD = 32'h3C3C3C3C;
    localparam logic [15:0] POLY     = 16'h0039;   // x^5 + x^4 + x^3 + 1 taps

    // Eight serial LFSR steps: returns {key byte (LSB first), next state}
    function automatic logic [23:0] lfsr_byte(input logic [15:0] s);
        logic [15:0] st;
        logic [7:0]  key;
        st  = s;
        key = '0;
        for (int b = 0; b < 8; b++) begin
            key[b] = st[15];
            st     = {st[14:0], 1'b0} ^ (st[15] ? POLY : 16'h0000);
        end
        return {key, st};
    endfunction

    logic              ready_en;
    logic [15:0]       lfsr, lfsr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PEND_W-1:0] pend, pend_nxt;
    logic [31:0]       data_nxt, sym_d;
    logic [3:0]        datak_nxt, sym_k;
    logic [7:0]        lane;
    logic [23:0]       ks;
    logic              skp_nxt, err_nxt, wrap, skp_now;

    assign skp_now  = (pend != '0) & ~in_hold;
    assign in_ready = ready_en & ~skp_now;

    // Per-cycle choice of SKP / data / idle, scrambling and SKP scheduling
    always_comb begin
        lfsr_nxt  = lfsr;
        data_nxt  = tx_data;
        datak_nxt = tx_datak;
        skp_nxt   = 1'b0;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        err_nxt   = err_skp_overflow;
        wrap      = 1'b0;
        sym_d     = '0;
        sym_k     = '0;
        lane      = '0;
        ks        = '0;
        if (ready_en) begin
            if (skp_now) begin
                data_nxt  = SKP_WORD;
                datak_nxt = 4'hF;
                skp_nxt   = 1'b1;
            end else begin
                // idle is an all-zero D word, so it goes through the same path
                if (in_valid) begin
                    sym_d = in_data;
                    sym_k = in_datak;
                end
                // lane 3 is first on the wire; a COM reseeds for the lanes after it
                for (int i = 3; i >= 0; i--) begin
                    lane = sym_d[8*i +: 8];
                    if (sym_k[i] && lane == COM_SYM) begin
                        lfsr_nxt = LFSR_SEED;
                    end else if (!(sym_k[i] && lane == SKP_SYM)) begin
                        ks = lfsr_byte(lfsr_nxt);
                        if (enable && !sym_k[i]) lane = lane ^ ks[23:16];
                        lfsr_nxt = ks[15:0];
                    end
                    data_nxt[8*i +: 8] = lane;
                end
                datak_nxt = sym_k;
                if (!enable) lfsr_nxt = LFSR_SEED;
                wrap    = (cnt == CNT_W'(SKP_INTERVAL - 1));
                cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
            end
            // request and service in one cycle cancel out
            if (wrap && !skp_now) begin
                if (pend == PEND_W'(PEND_MAX)) err_nxt  = 1'b1;
                else                           pend_nxt = pend + PEND_W'(1);
            end else if (!wrap && skp_now) begin
                pend_nxt = pend - PEND_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            ready_en         <= 1'b0;
            lfsr             <= LFSR_SEED;
            cnt              <= '0;
            pend             <= '0;
            tx_data          <= '0;
            tx_datak         <= '0;
            skp_sent         <= 1'b0;
            err_skp_overflow <= 1'b0;
        end else begin
            ready_en         <= 1'b1;
            lfsr             <= lfsr_nxt;
            cnt              <= cnt_nxt;
            pend             <= pend_nxt;
            tx_data          <= data_nxt;
            tx_datak         <= datak_nxt;
            skp_sent         <= skp_nxt;
            err_skp_overflow <= err_nxt;
        end
    end

`ifdef USB3_TX_SKP_STATS_EN
    // Saturating count of SKP words sent
    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            skp_count <= '0;
        end else if (skp_nxt && skp_count != 16'hFFFF) begin
            skp_count <= skp_count + 16'd1;
        end
    end
`endif

endmodule
